dmx_channel_pwm: RTL
====================

Name: dmx_channel_pwm

Overview:
- Downstream consumer of the DMX512 receiver.
- Takes the receiver's per-slot byte stream and filters for start code 0x00.
- Captures a window of NUM_CH consecutive channels beginning at a runtime start address, double-buffered per frame.
- Drives NUM_CH 8-bit PWM outputs (LED dimming) with loss-of-signal handling.

Parameters:
NUM_CH, 8, number of captured channels / PWM outputs (1..32)
CLK_FREQ, 12090000, system clock in Hz
PWM_DIV, 4, clocks per PWM tick; PWM period = 255*PWM_DIV clocks
LOS_TIMEOUT_MS, 1000, time without a committed frame before signal loss

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  block enable
start_addr  in  9  first DMX channel of window (valid 1..511; 0 means no capture)
rx_valid  in  1  one-cycle strobe: rx_slot/rx_data valid
rx_slot  in  10  slot index, 0 = start code, 1..512 = channels
rx_data  in  8  slot byte
rx_frame_done  in  1  one-cycle strobe: frame ended cleanly
rx_frame_abort  in  1  one-cycle strobe: frame error (break/stop-bit fault)
los_hold  in  1  1 = hold last levels on LOS, 0 = blackout
pwm_out  out  NUM_CH  PWM outputs, bit i = channel start_addr+i
levels_flat  out  8*NUM_CH  committed levels, channel i at [8i+7:8i]
frame_count  out  16  committed frame counter
signal_ok  out  1  high while frames arrive within LOS timeout
start_code_err  out  1  one-cycle pulse on non-zero start code

Behaviour:
- Reset values:
  - outputs: pwm_out=0, levels_flat=0, frame_count=0, signal_ok=0, start_code_err=0
  - internal: shadow regs=0, got-mask=0, PWM counter/prescaler=0, LOS counter=0, FSM=WAIT_SC
- FSM states: WAIT_SC, CAPTURE, SKIP.
  - WAIT_SC: rx_valid with slot 0 and data 0x00 -> CAPTURE; latch start_addr into addr_q, clear got-mask.
  - WAIT_SC: rx_valid with slot 0 and data non-zero -> SKIP; start_code_err pulses the next cycle.
  - CAPTURE: rx_valid with slot s, idx = s - addr_q. If 0 <= idx < NUM_CH and s <= 512, write shadow[idx] = rx_data and set got[idx]. Other slots are ignored.
  - CAPTURE + rx_valid slot 0 (new frame without done): discard shadow/got-mask, re-evaluate the start code as in WAIT_SC.
  - CAPTURE + rx_frame_done: commit shadow[i] to level[i] only where got[i]=1; unreceived channels (short frame) keep previous level. frame_count +1, wraps 0xFFFF -> 0. LOS counter cleared, signal_ok=1. -> WAIT_SC.
  - rx_frame_abort in any state: no commit, no count -> WAIT_SC.
  - rx_frame_done in WAIT_SC/SKIP: no commit -> WAIT_SC.
- Simultaneous events:
  - abort beats done.
  - done or abort beats rx_valid in the same cycle; that byte is dropped.
- Address rules:
  - addr_q frozen for the whole frame; start_addr changes mid-frame take effect from the next start code.
  - addr_q=0: nothing is captured, but frames still count.
- Latency: levels_flat and frame_count update 1 clk after the rx_frame_done cycle.
- PWM:
  - prescaler counts 0..PWM_DIV-1; tick on wrap.
  - 8-bit pwm_cnt counts 0..254 on ticks, wraps to 0.
  - Compare registers load from level[] only when pwm_cnt wraps to 0 (glitch-free update).
  - pwm_out[i] = (pwm_cnt < cmp[i]), registered. Level 0 = constant low, 255 = constant high.
- LOS:
  - Counter increments each clk, saturates at LOS_CYCLES = (CLK_FREQ/1000)*LOS_TIMEOUT_MS.
  - On reaching LOS_CYCLES: signal_ok=0. If los_hold=0, all levels are cleared to 0 in the same cycle. Cleared levels propagate to PWM at the next period.
  - los_hold sampled continuously while in LOS; a 1->0 change during LOS blacks out.
- enable=0:
  - pwm_out forced 0 combinationally from the registered value.
  - FSM held in WAIT_SC; rx inputs ignored.
  - Levels retained; LOS counter keeps running.
- Reset mid-frame returns everything to reset values immediately (asynchronous).

Test Plan:
- start_addr=1, frame with slot0=0x00, slots1..8 = 0x00,0x10,0x40,0x80,0xC0,0xFE,0xFF,0x01, then done -> levels_flat matches 1 clk later; frame_count=1; signal_ok=1. Over one PWM period (1020 clk): pwm_out[6] always 1, pwm_out[0] always 0, pwm_out[3] high 128*4 clk.
- start_addr=510, frame with 512 slots (slots 510..512 = 0x11,0x22,0x33) -> ch0..2 updated, ch3..7 keep prior values.
- Start code 0xCC with full frame and done -> start_code_err pulses once; levels and frame_count unchanged.
- Valid frame aborted at slot 5, then done -> no commit, frame_count unchanged. Also: done and abort in the same cycle -> no commit.
- Short frame (slots 1..3 only) after a full frame -> ch0..2 new, ch3..7 hold. start_addr changed mid-frame -> capture still uses the latched address.
- LOS_TIMEOUT_MS reduced for sim:
  - no frames, los_hold=1 -> signal_ok falls exactly at LOS_CYCLES, levels hold.
  - repeat with los_hold=0 -> levels 0, pwm_out all 0 from next period.
  - next valid frame restores signal_ok.

Source files
------------

// File: rtl/dmx_channel_pwm.sv
// DMX512 channel-window capture with per-frame double buffering, driving NUM_CH
// 8-bit PWM outputs with loss-of-signal hold/blackout behaviour.
module dmx_channel_pwm #(
  parameter int NUM_CH         = 8,
  parameter int CLK_FREQ       = 12090000,
  parameter int PWM_DIV        = 4,
  parameter int LOS_TIMEOUT_MS = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [8:0]            start_addr,
  input  logic                  rx_valid,
  input  logic [9:0]            rx_slot,
  input  logic [7:0]            rx_data,
  input  logic                  rx_frame_done,
  input  logic                  rx_frame_abort,
  input  logic                  los_hold,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic [8*NUM_CH-1:0]   levels_flat,
  output logic [15:0]           frame_count,
  output logic                  signal_ok,
  output logic                  start_code_err
);

  localparam int LOS_CYCLES = (CLK_FREQ / 1000) * LOS_TIMEOUT_MS;
  localparam int LW         = $clog2(LOS_CYCLES + 1);
  localparam int PW         = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [LW-1:0] LOS_MAX = LW'(LOS_CYCLES);
  localparam logic [LW-1:0] LOS_PRE = LW'(LOS_CYCLES - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PWM_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_SC = 2'd0,
    CAPTURE = 2'd1,
    SKIP    = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;

  logic [8:0]              r_addrQ;
  logic [NUM_CH-1:0][7:0]  r_shadow;
  logic [NUM_CH-1:0][7:0]  r_level;
  logic [NUM_CH-1:0][7:0]  r_cmp;
  logic [NUM_CH-1:0]       r_got;
  logic [NUM_CH-1:0]       r_pwm;
  logic [15:0]             r_frameCount;
  logic                    r_signalOk;
  logic                    r_scErr;
  logic [LW-1:0]           r_losCnt;
  logic [PW-1:0]           r_pre;
  logic [7:0]              r_pwmCnt;

  logic                    w_abort;
  logic                    w_done;
  logic                    w_valid;
  logic [9:0]              w_slotDiff;
  logic                    w_inWindow;
  logic                    w_startFrame;
  logic                    w_scErr;
  logic                    w_capture;
  logic                    w_commit;
  logic                    w_blackout;
  logic                    w_tick;
  logic                    w_wrap;

  // Abort beats done, and either of them drops a byte strobed in the same cycle.
  assign w_abort    = enable & rx_frame_abort;
  assign w_done     = enable & rx_frame_done & ~rx_frame_abort;
  assign w_valid    = enable & rx_valid & ~rx_frame_done & ~rx_frame_abort;
  assign w_slotDiff = rx_slot - {1'b0, r_addrQ};
  assign w_inWindow = (r_addrQ != 9'd0) && (rx_slot >= {1'b0, r_addrQ}) &&
                      (rx_slot <= 10'd512) && (w_slotDiff < 10'(NUM_CH));

  always_comb begin
    w_nextState  = r_state;
    w_startFrame = 1'b0;
    w_scErr      = 1'b0;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    if (!enable || w_abort) begin
      w_nextState = WAIT_SC;
    end else if (w_done) begin
      w_nextState = WAIT_SC;
      w_commit    = (r_state == CAPTURE);
    end else if (w_valid && (rx_slot == 10'd0)) begin
      if (rx_data == 8'h00) begin
        w_nextState  = CAPTURE;
        w_startFrame = 1'b1;
      end else begin
        w_nextState = SKIP;
        w_scErr     = 1'b1;
      end
    end else if (w_valid && (r_state == CAPTURE) && w_inWindow) begin
      w_capture = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_SC;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Blackout fires on the cycle the LOS count is reached and keeps firing while held in LOS.
  assign w_blackout = ~los_hold & ~w_commit & ((r_losCnt == LOS_PRE) | (r_losCnt == LOS_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addrQ      <= '0;
      r_shadow     <= '0;
      r_got        <= '0;
      r_level      <= '0;
      r_frameCount <= '0;
      r_scErr      <= 1'b0;
    end else begin
      r_scErr <= w_scErr;
      if (w_startFrame) begin
        r_addrQ  <= start_addr;
        r_got    <= '0;
        r_shadow <= '0;
      end else if (w_capture) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (w_slotDiff == 10'(i)) begin
            r_shadow[i] <= rx_data;
            r_got[i]    <= 1'b1;
          end
        end
      end
      if (w_commit) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (r_got[i]) begin
            r_level[i] <= r_shadow[i];
          end
        end
        r_frameCount <= r_frameCount + 16'd1;
      end else if (w_blackout) begin
        r_level <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_losCnt   <= '0;
      r_signalOk <= 1'b0;
    end else if (w_commit) begin
      r_losCnt   <= '0;
      r_signalOk <= 1'b1;
    end else if (r_losCnt != LOS_MAX) begin
      r_losCnt <= r_losCnt + LW'(1);
      if (r_losCnt == LOS_PRE) begin
        r_signalOk <= 1'b0;
      end
    end
  end

  assign w_tick = (r_pre == PRE_MAX);
  assign w_wrap = w_tick && (r_pwmCnt == 8'd254);

  // Compare values only reload at the period boundary so a level change never glitches a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre    <= '0;
      r_pwmCnt <= '0;
      r_cmp    <= '0;
      r_pwm    <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick) begin
        r_pwmCnt <= (r_pwmCnt == 8'd254) ? 8'd0 : r_pwmCnt + 8'd1;
      end
      if (w_wrap) begin
        r_cmp <= r_level;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        r_pwm[i] <= (r_pwmCnt < r_cmp[i]);
      end
    end
  end

  assign pwm_out        = enable ? r_pwm : '0;
  assign levels_flat    = r_level;
  assign frame_count    = r_frameCount;
  assign signal_ok      = r_signalOk;
  assign start_code_err = r_scErr;

endmodule
